// File: rtl/ball_motion.sv
// Pong ball position engine: moves the ball once per frame, bounces it off walls and
// paddles, flags a score, and parks it at the serve point until the next serve.
module ball_motion #(
   parameter int SCREEN_W    = 640,
   parameter int SCREEN_H    = 480,
   parameter int BALL_SIZE   = 8,
   parameter int SPEED       = 2,
   parameter int START_X     = 316,
   parameter int START_Y     = 236,
   parameter int L_PADDLE_X  = 20,
   parameter int R_PADDLE_X  = 610,
   parameter int PADDLE_W    = 10,
   parameter int PADDLE_H    = 64,
   parameter int HOLD_FRAMES = 60
) (
   input  logic       pixel_clk,
   input  logic       rst,
   input  logic       frame_tick,
   input  logic       serve,
   input  logic [9:0] l_paddle_y,
   input  logic [9:0] r_paddle_y,
   output logic [9:0] ball_x,
   output logic [9:0] ball_y,
   output logic       dir_x,
   output logic       dir_y,
   output logic       score_l,
   output logic       score_r,
   output logic       in_play
);

   // frame_tick and serve are single-cycle strobes with no back-pressure: a strobe is
   // consumed in the cycle it is high, or dropped if the current state has no use for it.
   // score_l/score_r are single-cycle strobes on the cycle the ball enters SCORED.

   localparam int CW = $clog2(HOLD_FRAMES + 1);

   localparam logic [10:0] W_11    = 11'(SCREEN_W);
   localparam logic [10:0] H_11    = 11'(SCREEN_H);
   localparam logic [10:0] BS_11   = 11'(BALL_SIZE);
   localparam logic [10:0] SP_11   = 11'(SPEED);
   localparam logic [10:0] PH_11   = 11'(PADDLE_H);
   localparam logic [10:0] L_EDGE  = 11'(L_PADDLE_X + PADDLE_W);
   localparam logic [10:0] R_EDGE  = 11'(R_PADDLE_X);
   localparam logic [9:0]  X_START = 10'(START_X);
   localparam logic [9:0]  Y_START = 10'(START_Y);

   typedef enum logic [1:0] {IDLE, PLAY, SCORED} state_t;

   state_t        state;
   logic [CW-1:0] hold_cnt;

   logic [10:0] bx, by, lp, rp;
   logic        ov_l, ov_r, hit_l, hit_r;
   logic        pt_l, pt_r;
   logic [9:0]  nx, ny;
   logic        ndx, ndy;

   // All geometry is evaluated in 11 bits so edge sums never wrap.
   assign bx = {1'b0, ball_x};
   assign by = {1'b0, ball_y};
   assign lp = {1'b0, l_paddle_y};
   assign rp = {1'b0, r_paddle_y};

   assign ov_l  = (by + BS_11 > lp) && (by < lp + PH_11);
   assign ov_r  = (by + BS_11 > rp) && (by < rp + PH_11);
   assign hit_l = (bx >= L_EDGE) && (bx - SP_11 <= L_EDGE) && ov_l;
   assign hit_r = (bx + BS_11 <= R_EDGE) && (bx + BS_11 + SP_11 >= R_EDGE) && ov_r;

   always_comb begin
      ny   = ball_y;
      ndy  = dir_y;
      nx   = ball_x;
      ndx  = dir_x;
      pt_l = 1'b0;
      pt_r = 1'b0;

      if (dir_y) begin
         if (by + BS_11 + SP_11 >= H_11) begin
            ny  = 10'(H_11 - BS_11);
            ndy = 1'b0;
         end else begin
            ny = 10'(by + SP_11);
         end
      end else if (by <= SP_11) begin
         ny  = 10'd0;
         ndy = 1'b1;
      end else begin
         ny = 10'(by - SP_11);
      end

      // Horizontal uses the same pre-tick position, so a corner hit reflects both axes.
      if (!dir_x) begin
         if (hit_l) begin
            nx  = 10'(L_EDGE);
            ndx = 1'b1;
         end else if (bx <= SP_11) begin
            nx   = 10'd0;
            ndx  = 1'b0;
            pt_r = 1'b1;
         end else begin
            nx = 10'(bx - SP_11);
         end
      end else begin
         if (hit_r) begin
            nx  = 10'(R_EDGE - BS_11);
            ndx = 1'b0;
         end else if (bx + BS_11 + SP_11 >= W_11) begin
            nx   = 10'(W_11 - BS_11);
            ndx  = 1'b1;
            pt_l = 1'b1;
         end else begin
            nx = 10'(bx + SP_11);
         end
      end
   end

   always_ff @(posedge pixel_clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         hold_cnt <= '0;
         ball_x   <= X_START;
         ball_y   <= Y_START;
         dir_x    <= 1'b1;
         dir_y    <= 1'b1;
         score_l  <= 1'b0;
         score_r  <= 1'b0;
         in_play  <= 1'b0;
      end else begin
         score_l <= 1'b0;
         score_r <= 1'b0;
         case (state)
            IDLE: begin
               // The serve cycle never moves the ball, even on a coincident frame_tick.
               if (serve) begin
                  state   <= PLAY;
                  in_play <= 1'b1;
                  dir_y   <= 1'b1;
               end
            end
            PLAY: begin
               if (frame_tick) begin
                  ball_x <= nx;
                  ball_y <= ny;
                  dir_x  <= ndx;
                  dir_y  <= ndy;
                  if (pt_l || pt_r) begin
                     state    <= SCORED;
                     in_play  <= 1'b0;
                     score_l  <= pt_l;
                     score_r  <= pt_r;
                     hold_cnt <= '0;
                  end
               end
            end
            SCORED: begin
               if (frame_tick) begin
                  if (hold_cnt == CW'(HOLD_FRAMES - 1)) begin
                     state    <= IDLE;
                     hold_cnt <= '0;
                     ball_x   <= X_START;
                     ball_y   <= Y_START;
                  end else begin
                     hold_cnt <= hold_cnt + 1'b1;
                  end
               end
            end
            default: begin
               state   <= IDLE;
               in_play <= 1'b0;
            end
         endcase
      end
   end

endmodule
